gpio_ctrl: RTL and testbench
============================

Name: gpio_ctrl

Overview:
- Parametrised, memory-mapped GPIO controller; successor to the single-register GPIO port.
- Adds per-pin direction, two-flop input synchronisation, rising/falling edge detection and a level interrupt line.
- Sits on the data-memory bus of the RISC-V core as a peripheral slave.
- Drives FPGA pins through `pin_out`/`pin_oe`.

Parameters:
- DATA_WIDTH, 8, number of GPIO pins (1..32).
- BUS_WIDTH, 32, bus data width; must be >= DATA_WIDTH.
- ADDR_WIDTH, 3, word-offset address width; 8 register slots.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- we  input  1  register write strobe, one cycle.
- re  input  1  register read strobe, one cycle.
- addr  input  ADDR_WIDTH  register word offset.
- wdata  input  BUS_WIDTH  write data; bits [DATA_WIDTH-1:0] used.
- rdata  output  BUS_WIDTH  read data, zero-extended.
- rvalid  output  1  high the cycle after an accepted `re`.
- pin_in  input  DATA_WIDTH  raw asynchronous pin inputs.
- pin_out  output  DATA_WIDTH  output values, equal to the OUT register.
- pin_oe  output  DATA_WIDTH  output enables, equal to the DIR register (1 = drive).
- irq  output  1  level interrupt: OR over (STAT & IRQ_EN).

Behaviour:
- Register map (word offsets):
  - 0 OUT, RW.
  - 1 DIR, RW.
  - 2 IN, RO: synchronised pin value.
  - 3 IRQ_EN, RW.
  - 4 RISE, RW: rising-edge select.
  - 5 FALL, RW: falling-edge select.
  - 6 STAT, read; write-1-to-clear.
  - 7 reserved: reads 0, writes ignored.
- Reset (`rst` low, asynchronous): all registers, synchroniser flops, previous-sample flops, `rdata`, `rvalid` and `irq` go to 0. Pins are therefore undriven.
- Writes:
  - Take effect at the clock edge where `we`=1; the new value is visible on `pin_out`/`pin_oe` the following cycle.
  - Bits above DATA_WIDTH are ignored.
  - Writes to IN are ignored.
- Reads:
  - `re` at edge N gives `rdata` valid and `rvalid`=1 after edge N+1 (1-cycle latency).
  - `rdata` holds its value until the next read.
  - `rvalid` is a single-cycle pulse.
- Simultaneous `we` and `re` to the same address: the read returns the old value.
- Input path: `pin_in` -> sync1 -> sync2, giving IN. Latency from a pin change to IN visibility is 2 clocks. A previous-sample register `prev` holds the last IN.
- Edge events:
  - rise[i] = IN[i] & ~prev[i] & RISE[i].
  - fall[i] = ~IN[i] & prev[i] & FALL[i].
  - evt = rise | fall.
- Status update: STAT_next = (STAT & ~(we && addr==6 ? wdata : 0)) | evt. A new event in the same cycle as a W1C on that bit wins, and the bit stays set.
- STAT bits latch regardless of IRQ_EN; IRQ_EN only masks `irq`.
- `irq` is registered: it asserts the cycle after STAT sets and deasserts the cycle after STAT or IRQ_EN clears.
- Edges on output-direction pins are still detected (loopback is visible).
- Reset mid-transaction: a pending `rvalid` is dropped; no read response is issued after reset is released.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- When defined:
  - Adds a parameter DEB_CYCLES, default 4, and a per-pin saturating counter after sync2.
  - IN[i] changes only after sync2[i] has differed from IN[i] for DEB_CYCLES consecutive clocks; the counter resets on any mismatch break.
  - Pin-to-IN latency becomes 2+DEB_CYCLES clocks. Glitches shorter than DEB_CYCLES produce no edge event.
- When undefined: IN = sync2 directly; no counters exist.

Decomposition:
- Shared package `gpio_pkg`:
  - Register offset constants: GPIO_OUT=0, GPIO_DIR=1, GPIO_IN=2, GPIO_IRQ_EN=3, GPIO_RISE=4, GPIO_FALL=5, GPIO_STAT=6.
  - Typedef `gpio_addr_t`.
- Natural sub-module `gpio_in_cond`: synchroniser, optional debouncer and edge detector. It outputs IN and the raw rise/fall vectors, and is instantiated once with DATA_WIDTH-wide vectors.
- Register file, bus decode and irq logic stay in `gpio_ctrl`.
- All flops use the team's standard asynchronous active-low reset flop macros.

Test Plan:
1. Reset, then read all 8 offsets -> every `rdata`=0, `rvalid` pulses once per read, `pin_oe`=0, `irq`=0.
2. Write OUT=0xA5, DIR=0x0F -> next cycle `pin_out`=0xA5, `pin_oe`=0x0F; reading offset 0 returns 0x000000A5 one cycle after `re`.
3. RISE=0x01, IRQ_EN=0x01, drive `pin_in`[0] 0->1 -> IN reads 0x01 after 2 clocks, STAT=0x01, `irq`=1 one cycle later. Write STAT=0x01 -> STAT=0, `irq`=0.
4. FALL=0x80, IRQ_EN=0; toggle `pin_in`[7] 1->0 -> STAT=0x80, `irq` stays 0. Then set IRQ_EN=0x80 -> `irq`=1 next cycle.
5. W1C on STAT bit 0 in the same cycle a new rising edge on pin 0 is detected -> STAT[0] remains 1.
6. With GPIO_DEBOUNCE_EN and DEB_CYCLES=4: a 3-cycle pulse on `pin_in`[1] -> no IN change and STAT=0. A 6-cycle pulse -> IN[1]=1 at 6 clocks after the edge and STAT[1] set (with RISE[1]=1).

Source files
------------

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register offsets and address type shared by the GPIO controller
package gpio_pkg;

    localparam int GPIO_ADDR_W = 3;

    typedef logic [GPIO_ADDR_W-1:0] gpio_addr_t;

    localparam gpio_addr_t GPIO_OUT    = 3'd0;
    localparam gpio_addr_t GPIO_DIR    = 3'd1;
    localparam gpio_addr_t GPIO_IN     = 3'd2;
    localparam gpio_addr_t GPIO_IRQ_EN = 3'd3;
    localparam gpio_addr_t GPIO_RISE   = 3'd4;
    localparam gpio_addr_t GPIO_FALL   = 3'd5;
    localparam gpio_addr_t GPIO_STAT   = 3'd6;

endpackage

// File: rtl/gpio_in_cond.sv
// rtl/gpio_in_cond.sv - pin synchroniser, optional debouncer (GPIO_DEBOUNCE_EN) and raw edge detector
module gpio_in_cond #(
    parameter int WIDTH = 8
`ifdef GPIO_DEBOUNCE_EN
    ,
    parameter int DEB_CYCLES = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] in_val,
    output logic [WIDTH-1:0] rise_raw,
    output logic [WIDTH-1:0] fall_raw
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;

    // two-flop synchroniser for the asynchronous pins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin_in;
            sync2 <= sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] deb;

    // per pin: accept a new level only after it has been stable for DEB_CYCLES clocks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
                        deb[i] <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign in_val = deb;
`else
    assign in_val = sync2;
`endif

    // previous sample of the conditioned input, used for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= '0;
        end else begin
            prev <= in_val;
        end
    end

    assign rise_raw = in_val & ~prev;
    assign fall_raw = ~in_val & prev;

endmodule

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - memory-mapped GPIO controller top; optional input debounce via GPIO_DEBOUNCE_EN
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 3
`ifdef GPIO_DEBOUNCE_EN
    ,
    parameter int DEB_CYCLES = 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [BUS_WIDTH-1:0]  wdata,
    output logic [BUS_WIDTH-1:0]  rdata,
    output logic                  rvalid,
    input  logic [DATA_WIDTH-1:0] pin_in,
    output logic [DATA_WIDTH-1:0] pin_out,
    output logic [DATA_WIDTH-1:0] pin_oe,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] dir_q;
    logic [DATA_WIDTH-1:0] ien_q;
    logic [DATA_WIDTH-1:0] rise_q;
    logic [DATA_WIDTH-1:0] fall_q;
    logic [DATA_WIDTH-1:0] stat_q;

    logic [DATA_WIDTH-1:0] in_val;
    logic [DATA_WIDTH-1:0] rise_raw;
    logic [DATA_WIDTH-1:0] fall_raw;
    logic [DATA_WIDTH-1:0] evt;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] stat_clr;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  unused_wdata;

    gpio_in_cond #(
        .WIDTH      (DATA_WIDTH)
`ifdef GPIO_DEBOUNCE_EN
        ,
        .DEB_CYCLES (DEB_CYCLES)
`endif
    ) u_in_cond (
        .clk      (clk),
        .rst      (rst),
        .pin_in   (pin_in),
        .in_val   (in_val),
        .rise_raw (rise_raw),
        .fall_raw (fall_raw)
    );

    // only the low DATA_WIDTH bits of a write carry pin state
    assign wd           = wdata[DATA_WIDTH-1:0];
    assign unused_wdata = ^wdata;

    assign evt      = (rise_raw & rise_q) | (fall_raw & fall_q);
    assign stat_clr = (we && (addr == ADDR_WIDTH'(GPIO_STAT))) ? wd : '0;

    // register writes; STAT is write-1-to-clear but a fresh event always wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q  <= '0;
            dir_q  <= '0;
            ien_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            stat_q <= '0;
        end else begin
            stat_q <= (stat_q & ~stat_clr) | evt;
            if (we) begin
                case (addr)
                    ADDR_WIDTH'(GPIO_OUT):    out_q  <= wd;
                    ADDR_WIDTH'(GPIO_DIR):    dir_q  <= wd;
                    ADDR_WIDTH'(GPIO_IRQ_EN): ien_q  <= wd;
                    ADDR_WIDTH'(GPIO_RISE):   rise_q <= wd;
                    ADDR_WIDTH'(GPIO_FALL):   fall_q <= wd;
                    default:                  ;
                endcase
            end
        end
    end

    // read mux over the pre-write register values
    always_comb begin
        rd_val = '0;
        case (addr)
            ADDR_WIDTH'(GPIO_OUT):    rd_val = out_q;
            ADDR_WIDTH'(GPIO_DIR):    rd_val = dir_q;
            ADDR_WIDTH'(GPIO_IN):     rd_val = in_val;
            ADDR_WIDTH'(GPIO_IRQ_EN): rd_val = ien_q;
            ADDR_WIDTH'(GPIO_RISE):   rd_val = rise_q;
            ADDR_WIDTH'(GPIO_FALL):   rd_val = fall_q;
            ADDR_WIDTH'(GPIO_STAT):   rd_val = stat_q;
            default:                  rd_val = '0;
        endcase
    end

    // one-cycle read response; rdata holds until the next read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                rdata <= BUS_WIDTH'(rd_val);
            end
        end
    end

    // registered level interrupt from masked status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(stat_q & ien_q);
        end
    end

    assign pin_out = out_q;
    assign pin_oe  = dir_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - randomized self-checking bench for gpio_ctrl against a behavioural model
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        rvalid;
    logic [7:0]  pin_in = 8'h0;
    logic [7:0]  pin_out;
    logic [7:0]  pin_oe;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: registers, response, and the history of pin samples at each clock edge
    logic [7:0]  m_out, m_dir, m_ien, m_rise, m_fall, m_stat;
    logic        m_irq, m_rvalid;
    logic [31:0] m_rdata;
    logic [7:0]  pq[$];

    gpio_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .re      (re),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .pin_oe  (pin_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_dir = 0; m_ien = 0; m_rise = 0; m_fall = 0; m_stat = 0;
        m_irq = 0; m_rvalid = 0; m_rdata = 0;
        pq = '{8'h0, 8'h0, 8'h0};
    endtask

    // IN seen by a read at this edge is the pin value sampled two edges earlier
    function automatic logic [7:0] model_read(input logic [2:0] a, input logic [7:0] in_now);
        case (a)
            3'd0: return m_out;
            3'd1: return m_dir;
            3'd2: return in_now;
            3'd3: return m_ien;
            3'd4: return m_rise;
            3'd5: return m_fall;
            3'd6: return m_stat;
            default: return 8'h0;
        endcase
    endfunction

    // advance model and DUT by one clock, then compare all visible outputs
    task automatic tick();
        logic [7:0] in_now, in_old, evt, clr;
        if (!rst) begin
            model_reset();
        end else begin
            pq.push_front(pin_in);
            in_now = pq[2];
            in_old = pq[3];
            evt = (in_now & ~in_old & m_rise) | (~in_now & in_old & m_fall);
            clr = (we && addr == 3'd6) ? wdata[7:0] : 8'h0;
            m_rvalid = re;
            if (re) m_rdata = {24'h0, model_read(addr, in_now)};
            m_irq  = |(m_stat & m_ien);
            m_stat = (m_stat & ~clr) | evt;
            if (we) begin
                case (addr)
                    3'd0: m_out  = wdata[7:0];
                    3'd1: m_dir  = wdata[7:0];
                    3'd3: m_ien  = wdata[7:0];
                    3'd4: m_rise = wdata[7:0];
                    3'd5: m_fall = wdata[7:0];
                    default: ;
                endcase
            end
            void'(pq.pop_back());
        end
        @(posedge clk);
        @(negedge clk);
        check("pin_out", {24'h0, pin_out}, {24'h0, m_out});
        check("pin_oe", {24'h0, pin_oe}, {24'h0, m_dir});
        check("irq", {31'h0, irq}, {31'h0, m_irq});
        check("rvalid", {31'h0, rvalid}, {31'h0, m_rvalid});
        check("rdata", rdata, m_rdata);
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        addr  = a;
        wdata = ($urandom() & 32'hFFFF_FF00) | {24'h0, d};
        we    = 1'b1;
        tick();
    endtask

    task automatic read_expect(input string tag, input logic [2:0] a, input logic [31:0] exp);
        addr = a;
        re   = 1'b1;
        tick();
        check(tag, rdata, exp);
        check({tag, "_rv"}, {31'h0, rvalid}, 32'h1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // reset state
        rst = 1'b0;
        idle(2);
        check("rst_oe", {24'h0, pin_oe}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rst = 1'b1;
        for (int a = 0; a < 8; a++) read_expect("rst_read", 3'(a), 32'h0);
        tick();
        check("rv_pulse", {31'h0, rvalid}, 32'h0);

        // output and direction registers
        write_reg(3'd0, 8'hA5);
        write_reg(3'd1, 8'h0F);
        check("out_a5", {24'h0, pin_out}, 32'hA5);
        check("oe_0f", {24'h0, pin_oe}, 32'h0F);
        read_expect("rd_out", 3'd0, 32'h0000_00A5);

        // rising edge on pin 0 with interrupt enabled, then W1C
        write_reg(3'd4, 8'h01);
        write_reg(3'd3, 8'h01);
        pin_in[0] = 1'b1;
        idle(2);
        read_expect("in_pin0", 3'd2, 32'h01);
        read_expect("stat_rise", 3'd6, 32'h01);
        check("irq_rise", {31'h0, irq}, 32'h1);
        write_reg(3'd6, 8'h01);
        read_expect("stat_clr", 3'd6, 32'h0);
        check("irq_clr", {31'h0, irq}, 32'h0);

        // falling edge on pin 7 latches while masked, then unmask
        write_reg(3'd5, 8'h80);
        write_reg(3'd3, 8'h00);
        pin_in[7] = 1'b1;
        idle(4);
        pin_in[7] = 1'b0;
        idle(3);
        read_expect("stat_fall", 3'd6, 32'h80);
        check("irq_masked", {31'h0, irq}, 32'h0);
        write_reg(3'd3, 8'h80);
        tick();
        check("irq_unmask", {31'h0, irq}, 32'h1);

        // W1C colliding with a new rising event keeps the bit set
        write_reg(3'd6, 8'hFF);
        pin_in[0] = 1'b0;
        idle(4);
        pin_in[0] = 1'b1;
        idle(2);
        write_reg(3'd6, 8'h01);
        read_expect("stat_collide", 3'd6, 32'h01);

        // simultaneous write and read of the same register returns the old value
        addr = 3'd0; wdata = 32'h0000_005A; we = 1'b1; re = 1'b1;
        tick();
        check("rw_old", rdata, 32'hA5);

        // reset with a read in flight: no response afterwards
        addr = 3'd1; re = 1'b1; rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rst_drop_rv", {31'h0, rvalid}, 32'h0);
        check("rst_drop_oe", {24'h0, pin_oe}, 32'h0);

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) pin_in = pin_in ^ 8'($urandom_range(0, 255));
            addr = 3'($urandom_range(0, 7));
            wdata = $urandom();
            we = ($urandom_range(0, 9) < 3);
            re = ($urandom_range(0, 9) < 4);
            if (c == 700) rst = 1'b0;
            if (c == 702) rst = 1'b1;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
